serial_subtractor_ctrl: RTL and testbench
=========================================

# serial_subtractor_ctrl

Bit-serial unsigned subtractor controller. It computes `a - b` by reusing a single `full_subtractor` cell, one bit per clock, LSB first. The controller handles operand capture, shifting, borrow chaining, the bit counter and the start/done handshake. It is the sequencing wrapper the lab datapaths use when area matters more than latency.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 1..32.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a subtraction; sampled only in IDLE.
- `a`  in  WIDTH: minuend; captured on the accepted `start` edge.
- `b`  in  WIDTH: subtrahend; captured on the accepted `start` edge.
- `busy`  out  1: high while state is RUN.
- `done`  out  1: one-cycle pulse; high while state is DONE.
- `diff`  out  WIDTH: result `(a - b) mod 2^WIDTH`; registered and held until the next completion.
- `borrow_out`  out  1: final borrow; equals 1 iff `a < b` unsigned; held with `diff`.

## Operation
- Internal state:
  - shift registers `a_sr` and `b_sr` (WIDTH each),
  - result shift register `d_sr` (WIDTH),
  - borrow flop `bq`,
  - bit counter `cnt` of width `$clog2(WIDTH+1)`,
  - FSM state.
- Instantiate exactly one `full_subtractor` with `x=a_sr[0]`, `y=b_sr[0]`, `z=bq`; its outputs are `d_bit` and `b_bit`. No other subtraction logic is permitted.
- FSM states are IDLE, RUN and DONE.
  - IDLE and `start`=1: load `a_sr<=a`, `b_sr<=b`, `bq<=0`, `cnt<=0`; go to RUN.
  - IDLE and `start`=0: stay in IDLE.
  - RUN, each cycle:
    - `d_sr<={d_bit, d_sr[WIDTH-1:1]}`, `bq<=b_bit`;
    - shift `a_sr` and `b_sr` right by 1 (MSB fill 0);
    - `cnt<=cnt+1`.
  - RUN with `cnt==WIDTH-1` (last bit): also load `diff<={d_bit, d_sr[WIDTH-1:1]}` and `borrow_out<=b_bit`; go to DONE.
  - DONE: go unconditionally to IDLE after one cycle.
- `start` is ignored in RUN and DONE. It is not queued: a request must be re-presented in IDLE.
- `a` and `b` are ignored except on the accepted `start` edge; changing them during RUN does not affect the result.
- `busy` and `done` are decoded directly from the FSM state register (glitch-free). They are never high at the same time.
- `WIDTH=1`: RUN lasts exactly one cycle; same rules apply.

## Timing
- Reset (async, any state, including mid-RUN): state=IDLE, `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, `cnt=0`, `bq=0`, all shift registers 0. The in-flight operation is discarded and no `done` is produced.
- First rising edge with `rst` low: normal operation.
- Let `start` be accepted on edge E.
  - `busy`=1 from E to E+WIDTH.
  - `diff` and `borrow_out` update on edge E+WIDTH.
  - `done`=1 for the single cycle between edges E+WIDTH and E+WIDTH+1.
  - FSM is back in IDLE after edge E+WIDTH+1.
- Latency from start to result-valid: WIDTH+1 cycles.
- Minimum issue interval: WIDTH+2 cycles.
- `start` held high continuously: one operation every WIDTH+2 cycles; each `done` pulse is followed by exactly one IDLE cycle before the next RUN.
- `diff` and `borrow_out` change only on completion edges or on reset. They are stable and valid whenever `done`=1 and remain so until the next completion.

## Test plan
- WIDTH=8, `a=100`, `b=37`, pulse `start` → `busy` high 8 cycles; `done` pulse on cycle 9; `diff=63`, `borrow_out=0`.
- WIDTH=8, `a=5`, `b=9` → `diff=8'hFC`, `borrow_out=1`. Then `a=0`, `b=1` → `diff=8'hFF`, `borrow_out=1`. Then `a=8'hFF`, `b=8'hFF` → `diff=0`, `borrow_out=0`.
- Pulse `start` again at cycle 3 of RUN, and change `a` and `b` mid-RUN → ignored; the result matches the originally captured operands; exactly one `done` pulse.
- Hold `start`=1 for 30 cycles with `a=200`, `b=55` → `done` pulses exactly every 10 cycles; `diff=145` each time; `busy` low during each DONE and IDLE cycle.
- Assert `rst` asynchronously (between edges) at RUN cycle 4 → `busy`, `done`, `diff` and `borrow_out` go to 0 immediately; no `done` is produced; a subsequent operation `a=10`, `b=3` gives `diff=7`.
- WIDTH=1 instance, all four `a`/`b` combinations → `busy` for 1 cycle, `done` on the next cycle:
  - `1-0` → `diff=1`, `borrow_out=0`
  - `0-1` → `diff=1`, `borrow_out=1`
  - `0-0` → `diff=0`, `borrow_out=0`
  - `1-1` → `diff=0`, `borrow_out=0`

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full_subtractor cell reused LSB first,
// one bit per clock, wrapped in a start/busy/done handshake.

// Single-bit full subtractor: x - y - z, difference d and borrow b.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic b
);
  assign d = x ^ y ^ z;
  assign b = (~x & y) | (~x & z) | (y & z);
endmodule

module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_shift;
  logic             bq;
  logic [CntW-1:0]  cnt;
  logic             d_bit, b_bit;

  full_subtractor u_fs (
    .x (a_sr[0]),
    .y (b_sr[0]),
    .z (bq),
    .d (d_bit),
    .b (b_bit)
  );

  // New result bit enters at the MSB; a 1-bit result is just the new bit.
  if (WIDTH == 1) begin : g_w1
    assign d_shift = d_bit;
  end else begin : g_wn
    assign d_shift = {d_bit, d_sr[WIDTH-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state: IDLE -> RUN on start, RUN for WIDTH cycles, one DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: operand capture, shifting, borrow chain and result load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      bq         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            bq   <= 1'b0;
            cnt  <= '0;
          end
        end
        StRun: begin
          d_sr <= d_shift;
          bq   <= b_bit;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cnt  <= cnt + CntW'(1);
          if (cnt == CntLast) begin
            diff       <= d_shift;
            borrow_out <= b_bit;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs straight from the state register.
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl with WIDTH=8 and WIDTH=1 instances.
module tb_serial_subtractor_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;
  logic       busy1, done1, borrow1;
  logic [0:0] diff1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (borrow8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (borrow1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation on the selected instance; optionally disturb start/a/b mid-RUN.
  task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_b, input bit disturb);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = 0;
    logic bz, dn;
    logic [7:0] dv;
    logic bv;
    @(negedge clk);
    a8 = a; b8 = b; a1 = a[0]; b1 = b[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      bz = w1 ? busy1 : busy8;
      dn = w1 ? done1 : done8;
      dv = w1 ? {7'b0, diff1} : diff8;
      bv = w1 ? borrow1 : borrow8;
      if (bz) busy_cnt++;
      if (dn) begin
        done_cnt++;
        done_at = i;
        check("diff_at_done", 32'(dv), 32'(exp_d));
        check("borrow_at_done", 32'(bv), 32'(exp_b));
        check("busy_low_in_done", 32'(bz), 32'd0);
      end
      if (disturb && i == 3) begin
        start = 1'b1; a8 = 8'hFF; b8 = 8'h00; a1 = 1'b1; b1 = 1'b0;
      end
      if (disturb && i == 4) start = 1'b0;
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy_cnt), w1 ? 32'd1 : 32'd8);
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_at), w1 ? 32'd2 : 32'd9);
    dv = w1 ? {7'b0, diff1} : diff8;
    check("diff_held", 32'(dv), 32'(exp_d));
  endtask

  initial begin
    int last_done;
    int ndone;
    bit prev_done;
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_borrow", 32'(borrow8), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
    run_op(1'b0, 8'd5, 8'd9, 8'hFC, 1'b1, 1'b0);
    run_op(1'b0, 8'd0, 8'd1, 8'hFF, 1'b1, 1'b0);
    run_op(1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    // Mid-RUN start pulse and operand change must be ignored: 0x30-0x11.
    run_op(1'b0, 8'h30, 8'h11, 8'h1F, 1'b0, 1'b1);

    // Continuous start: one completion every WIDTH+2 = 10 cycles.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd55; start = 1'b1;
    last_done = 0; ndone = 0; prev_done = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 30) start = 1'b0;
      if (prev_done) check("busy_low_in_idle", 32'(busy8), 32'd0);
      prev_done = done8;
      if (done8) begin
        ndone++;
        check("stream_diff", 32'(diff8), 32'd145);
        check("stream_busy_in_done", 32'(busy8), 32'd0);
        check("stream_interval", 32'(k - last_done), ndone == 1 ? 32'd9 : 32'd10);
        last_done = k;
      end
    end
    check("stream_count", 32'(ndone), 32'd3);
    repeat (12) @(negedge clk);

    // Asynchronous reset in RUN cycle 4 discards the operation.
    a8 = 8'd50; b8 = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy8), 32'd0);
    check("async_rst_done", 32'(done8), 32'd0);
    check("async_rst_diff", 32'(diff8), 32'd0);
    check("async_rst_borrow", 32'(borrow8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("no_done_after_rst", 32'(ndone), 32'd0);
    run_op(1'b0, 8'd10, 8'd3, 8'd7, 1'b0, 1'b0);

    // WIDTH=1 instance, all operand combinations.
    run_op(1'b1, 8'd1, 8'd0, 8'd1, 1'b0, 1'b0);
    run_op(1'b1, 8'd0, 8'd1, 8'd1, 1'b1, 1'b0);
    run_op(1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    run_op(1'b1, 8'd1, 8'd1, 8'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
